wb_mem_slave: RTL and testbench
===============================

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of 16-bit memory words.
REQ-002 SHALL have parameter DATA_WAIT, default 1, wait cycles (0..7) before data-port ack.
REQ-003 SHALL have parameter INST_WAIT, default 0, wait cycles (0..7) before inst-port ack.
REQ-004 SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have wb_cyc  input  1  data-port cycle valid.
REQ-007 SHALL have wb_stb  input  1  data-port strobe.
REQ-008 SHALL have wb_we  input  1  data-port write enable (1 = write).
REQ-009 SHALL have wb_adr  input  13  data-port word address.
REQ-010 SHALL have wb_dat_i  input  16  data-port write data.
REQ-011 SHALL have wb_dat_o  output  16  data-port read data.
REQ-012 SHALL have wb_ack  output  1  data-port acknowledge.
REQ-013 SHALL have wb_inst_cyc  input  1  instruction-port cycle valid.
REQ-014 SHALL have wb_inst_stb  input  1  instruction-port strobe.
REQ-015 SHALL have wb_inst_pc  input  13  instruction word address.
REQ-016 SHALL have wb_inst_o  output  16  instruction read data.
REQ-017 SHALL have wb_inst_ack  output  1  instruction-port acknowledge.

Function
REQ-018 Each port SHALL run an independent FSM: IDLE, WAIT, ACK, GAP.
REQ-019 IDLE SHALL latch address, we and write data when cyc&stb=1, then enter WAIT if wait>0, else ACK.
REQ-020 WAIT SHALL count exactly the port's wait value of cycles, then enter ACK.
REQ-021 ACK SHALL assert ack for exactly one cycle, then enter GAP; GAP SHALL last one cycle ignoring all inputs, then enter IDLE.
REQ-022 Request-to-ack latency SHALL be wait+1 cycles (edge sampling cyc&stb to ack high).
REQ-023 A data write SHALL update memory at the clock edge ending the ACK cycle, using latched address/data.
REQ-024 Read data SHALL be valid on the corresponding *_o bus during the ACK cycle only; *_o SHALL be 0 in all other cycles.
REQ-025 Instruction port SHALL be read-only; it SHALL ignore write semantics.
REQ-026 If cyc or stb drops while in WAIT, FSM SHALL return to IDLE with no ack and no write (abort).
REQ-027 Addresses >= DEPTH SHALL be acked normally; writes discarded, reads return 16'h0000.
REQ-028 Same-cycle data write and instruction read of one address SHALL return pre-write (old) data to the instruction port.
REQ-029 Both ports MAY ack in the same cycle; neither port SHALL stall the other.
REQ-030 Latched request fields SHALL NOT change between IDLE exit and ACK even if bus inputs change.

Reset
REQ-031 On rst both FSMs SHALL go to IDLE; wb_ack, wb_inst_ack = 0; wb_dat_o, wb_inst_o = 0; wait counters = 0.
REQ-032 Reset asserted mid-transaction SHALL cancel it with no ack and no memory write.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 Data width 16, address width 13, and FSM state encodings SHALL live in the shared define.v package.
REQ-035 Per-port FSM + wait counter SHALL be one sub-module, wb_slave_port, instantiated twice; memory array resides in wb_mem_slave.

Verification
REQ-036 DATA_WAIT=1: write adr 13'h0010 dat 16'hBEEF -> wb_ack high exactly 2 cycles after request, once; read back returns 16'hBEEF in ack cycle.
REQ-037 INST_WAIT=0: inst read pc 13'h0010 after above -> wb_inst_ack 1 cycle later with wb_inst_o=16'hBEEF, 0 in surrounding cycles.
REQ-038 Same-cycle ACK: data write 16'h1234 to 13'h0020 while inst reads 13'h0020 (old 16'h0000) -> wb_inst_o=16'h0000; next inst read -> 16'h1234.
REQ-039 DATA_WAIT=3: drop wb_cyc in 2nd WAIT cycle of write to 13'h0030 -> no ack; later read of 13'h0030 returns prior value.
REQ-040 Read adr 13'h1FFF with DEPTH=4096 -> ack after wait+1 cycles, wb_dat_o=16'h0000; write there leaves all in-range words unchanged.
REQ-041 rst pulsed during WAIT of a write -> no ack, outputs 0 next cycle, memory unchanged; subsequent request served normally.

Source files
------------

// File: rtl/wb_mem_slave_pkg.sv
// Shared widths, port FSM encoding and request record for the dual-port Wishbone memory slave.
package wb_mem_slave_pkg;
    localparam int DW = 16;
    localparam int AW = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } port_state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } port_req_t;

    function automatic logic in_range(input logic [AW-1:0] adr, input int unsigned depth);
        return {{(32-AW){1'b0}}, adr} < depth;
    endfunction
endpackage

// File: rtl/wb_mem_slave_if.sv
// Data and instruction Wishbone ports of the memory slave bundled as one interface.
interface wb_mem_slave_if;
    import wb_mem_slave_pkg::*;

    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack;
    logic          wb_inst_cyc;
    logic          wb_inst_stb;
    logic [AW-1:0] wb_inst_pc;
    logic [DW-1:0] wb_inst_o;
    logic          wb_inst_ack;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_inst_cyc, wb_inst_stb, wb_inst_pc,
        output wb_dat_o, wb_ack, wb_inst_o, wb_inst_ack
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_inst_cyc, wb_inst_stb, wb_inst_pc,
        input  wb_dat_o, wb_ack, wb_inst_o, wb_inst_ack
    );
endinterface

// File: rtl/wb_mem_slave_port.sv
// One Wishbone port sequencer: latches a request, waits WAIT_CYC cycles, acks once, then idles a cycle.
// state   | meaning
// IDLE    | waiting for cyc&stb, latches request fields
// WAIT    | counting down wait cycles, aborts if cyc&stb drop
// ACK     | ack high for one cycle, write commits at its closing edge
// GAP     | one dead cycle, inputs ignored
module wb_slave_port
    import wb_mem_slave_pkg::*;
#(
    parameter int WAIT_CYC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cyc,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [AW-1:0] i_adr,
    input  logic [DW-1:0] i_dat,
    output logic          o_ack,
    output logic          o_rd_load,
    output logic [AW-1:0] o_rd_adr,
    output logic          o_wr_commit,
    output logic [AW-1:0] o_wr_adr,
    output logic [DW-1:0] o_wr_dat
);
    localparam logic [2:0] CNT_INIT = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

    port_state_t r_state;
    logic [2:0]  r_cnt;
    port_req_t   r_req;
    logic        r_ack;

    logic w_req;
    logic w_to_ack;
    logic w_cur_we;

    always_comb begin
        w_req    = i_cyc & i_stb;
        w_to_ack = 1'b0;
        if (r_state == ST_IDLE)
            w_to_ack = w_req && (WAIT_CYC == 0);
        else if (r_state == ST_WAIT)
            w_to_ack = w_req && (r_cnt == 3'd0);
    end

    // With zero wait the read is launched from the bus itself, since the latch lands on the same edge.
    assign w_cur_we    = (r_state == ST_IDLE) ? i_we  : r_req.we;
    assign o_rd_adr    = (r_state == ST_IDLE) ? i_adr : r_req.adr;
    assign o_rd_load   = w_to_ack & ~w_cur_we;
    assign o_wr_commit = (r_state == ST_ACK) & r_req.we;
    assign o_wr_adr    = r_req.adr;
    assign o_wr_dat    = r_req.dat;
    assign o_ack       = r_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_ack   <= 1'b0;
            r_req   <= '0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_req.we  <= i_we;
                        r_req.adr <= i_adr;
                        r_req.dat <= i_dat;
                        if (WAIT_CYC == 0) begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                    end else if (r_cnt == 3'd0) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_ACK:  r_state <= ST_GAP;
                ST_GAP:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/wb_mem_slave.sv
// Dual-port 16-bit memory: read/write data port plus read-only instruction port, each with its own sequencer.
module wb_mem_slave
    import wb_mem_slave_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int DATA_WAIT = 1,
    parameter int INST_WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    wb_mem_slave_if.slave bus
);
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dat_o;
    logic [DW-1:0] r_inst_o;

    logic          w_d_ack, w_d_rd_load, w_d_wr_commit;
    logic [AW-1:0] w_d_rd_adr, w_d_wr_adr;
    logic [DW-1:0] w_d_wr_dat;
    logic          w_i_ack, w_i_rd_load, w_i_wr_commit;
    logic [AW-1:0] w_i_rd_adr, w_i_wr_adr;
    logic [DW-1:0] w_i_wr_dat;
    logic          w_d_wr_en;
    logic          w_bypass;
    logic          w_unused_inst;

    wb_slave_port #(.WAIT_CYC(DATA_WAIT)) u_data (
        .clk         (clk),
        .rst         (rst),
        .i_cyc       (bus.wb_cyc),
        .i_stb       (bus.wb_stb),
        .i_we        (bus.wb_we),
        .i_adr       (bus.wb_adr),
        .i_dat       (bus.wb_dat_i),
        .o_ack       (w_d_ack),
        .o_rd_load   (w_d_rd_load),
        .o_rd_adr    (w_d_rd_adr),
        .o_wr_commit (w_d_wr_commit),
        .o_wr_adr    (w_d_wr_adr),
        .o_wr_dat    (w_d_wr_dat)
    );

    wb_slave_port #(.WAIT_CYC(INST_WAIT)) u_inst (
        .clk         (clk),
        .rst         (rst),
        .i_cyc       (bus.wb_inst_cyc),
        .i_stb       (bus.wb_inst_stb),
        .i_we        (1'b0),
        .i_adr       (bus.wb_inst_pc),
        .i_dat       ('0),
        .o_ack       (w_i_ack),
        .o_rd_load   (w_i_rd_load),
        .o_rd_adr    (w_i_rd_adr),
        .o_wr_commit (w_i_wr_commit),
        .o_wr_adr    (w_i_wr_adr),
        .o_wr_dat    (w_i_wr_dat)
    );

    assign w_unused_inst = ^{w_i_wr_commit, w_i_wr_adr, w_i_wr_dat};

    assign w_d_wr_en = w_d_wr_commit & in_range(w_d_wr_adr, DEPTH_U) & ~rst;
    // A write landing on the edge the instruction port loads is already part of memory from that edge on.
    assign w_bypass  = w_d_wr_en & (w_d_wr_adr == w_i_rd_adr);

    always_ff @(posedge clk) begin
        if (w_d_wr_en)
            r_mem[w_d_wr_adr[IW-1:0]] <= w_d_wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat_o  <= '0;
            r_inst_o <= '0;
        end else begin
            r_dat_o  <= '0;
            r_inst_o <= '0;
            if (w_d_rd_load && in_range(w_d_rd_adr, DEPTH_U))
                r_dat_o <= r_mem[w_d_rd_adr[IW-1:0]];
            if (w_i_rd_load && in_range(w_i_rd_adr, DEPTH_U))
                r_inst_o <= w_bypass ? w_d_wr_dat : r_mem[w_i_rd_adr[IW-1:0]];
        end
    end

    assign bus.wb_ack      = w_d_ack;
    assign bus.wb_dat_o    = r_dat_o;
    assign bus.wb_inst_ack = w_i_ack;
    assign bus.wb_inst_o   = r_inst_o;
endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: two instances (data wait 1/inst wait 0 and data wait 3/inst wait 2)
// checked every cycle against a transaction-level memory model plus literal expectations.
module tb_wb_mem_slave;
    localparam int NCYC = 2048;

    logic clk;
    int   cyc_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic        rst    [2];
    logic        d_cyc  [2];
    logic        d_stb  [2];
    logic        d_we   [2];
    logic [12:0] d_adr  [2];
    logic [15:0] d_dati [2];
    logic        i_cyc  [2];
    logic        i_stb  [2];
    logic [12:0] i_pc   [2];
    logic        o_dack [2];
    logic [15:0] o_ddat [2];
    logic        o_iack [2];
    logic [15:0] o_idat [2];

    wb_mem_slave_if bus0();
    wb_mem_slave_if bus1();

    assign bus0.wb_cyc = d_cyc[0];  assign bus1.wb_cyc = d_cyc[1];
    assign bus0.wb_stb = d_stb[0];  assign bus1.wb_stb = d_stb[1];
    assign bus0.wb_we  = d_we[0];   assign bus1.wb_we  = d_we[1];
    assign bus0.wb_adr = d_adr[0];  assign bus1.wb_adr = d_adr[1];
    assign bus0.wb_dat_i = d_dati[0];  assign bus1.wb_dat_i = d_dati[1];
    assign bus0.wb_inst_cyc = i_cyc[0];  assign bus1.wb_inst_cyc = i_cyc[1];
    assign bus0.wb_inst_stb = i_stb[0];  assign bus1.wb_inst_stb = i_stb[1];
    assign bus0.wb_inst_pc  = i_pc[0];   assign bus1.wb_inst_pc  = i_pc[1];
    assign o_dack[0] = bus0.wb_ack;      assign o_dack[1] = bus1.wb_ack;
    assign o_ddat[0] = bus0.wb_dat_o;    assign o_ddat[1] = bus1.wb_dat_o;
    assign o_iack[0] = bus0.wb_inst_ack; assign o_iack[1] = bus1.wb_inst_ack;
    assign o_idat[0] = bus0.wb_inst_o;   assign o_idat[1] = bus1.wb_inst_o;

    wb_mem_slave #(.DEPTH(4096), .DATA_WAIT(1), .INST_WAIT(0)) dut0 (
        .clk(clk), .rst(rst[0]), .bus(bus0));
    wb_mem_slave #(.DEPTH(4096), .DATA_WAIT(3), .INST_WAIT(2)) dut1 (
        .clk(clk), .rst(rst[1]), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Model: expected ack cycles per port, and memory updated when each write's ack cycle has ended.
    typedef struct { int d; int cyc; bit [12:0] adr; bit [15:0] dat; } wr_t;
    wr_t       pw[$];
    bit [15:0] mmem     [2][4096];
    bit        exp_dack [2][NCYC];
    bit        exp_drd  [2][NCYC];
    bit [12:0] exp_dadr [2][NCYC];
    bit        exp_iack [2][NCYC];
    bit [12:0] exp_iadr [2][NCYC];

    function automatic int dwait(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int iwait(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit [15:0] mrd(input int d, input bit [12:0] a);
        return (a < 13'd4096) ? mmem[d][a] : 16'h0000;
    endfunction

    task automatic apply_writes(input int d);
        int i = 0;
        while (i < pw.size()) begin
            if (pw[i].d == d && pw[i].cyc <= cyc_n) begin
                if (pw[i].adr < 13'd4096) mmem[d][pw[i].adr] = pw[i].dat;
                pw.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        if (cyc_n >= 1 && cyc_n < NCYC) begin
            for (int d = 0; d < 2; d++) begin
                bit        ea;
                bit [15:0] ed;
                apply_writes(d);
                ea = exp_dack[d][cyc_n];
                ed = (ea && exp_drd[d][cyc_n]) ? mrd(d, exp_dadr[d][cyc_n]) : 16'h0000;
                chk($sformatf("dut%0d wb_ack", d), {15'd0, o_dack[d]}, {15'd0, ea});
                chk($sformatf("dut%0d wb_dat_o", d), o_ddat[d], ed);
                ea = exp_iack[d][cyc_n];
                ed = ea ? mrd(d, exp_iadr[d][cyc_n]) : 16'h0000;
                chk($sformatf("dut%0d wb_inst_ack", d), {15'd0, o_iack[d]}, {15'd0, ea});
                chk($sformatf("dut%0d wb_inst_o", d), o_idat[d], ed);
            end
        end else if (cyc_n >= NCYC) begin
            n_fail++;
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc_n, NCYC);
            $fatal(1, "cycle budget exceeded");
        end
    end

    // Called just after a negedge; bus address/data are scrambled after the request edge.
    task automatic data_req(input int d, input bit we, input bit [12:0] adr,
                            input bit [15:0] dat, output bit [15:0] got);
        int w = dwait(d);
        int n = cyc_n + 1;
        d_cyc[d] = 1'b1; d_stb[d] = 1'b1; d_we[d] = we; d_adr[d] = adr; d_dati[d] = dat;
        exp_dack[d][n+w] = 1'b1;
        exp_drd[d][n+w]  = !we;
        exp_dadr[d][n+w] = adr;
        if (we) pw.push_back('{d, n + w + 1, adr, dat});
        repeat (w + 1) begin
            @(negedge clk);
            d_adr[d] = adr ^ 13'h1555;
            d_dati[d] = ~dat;
        end
        got = o_ddat[d];
        d_cyc[d] = 1'b0; d_stb[d] = 1'b0; d_we[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic inst_req(input int d, input bit [12:0] pc, output bit [15:0] got);
        int w = iwait(d);
        int n = cyc_n + 1;
        i_cyc[d] = 1'b1; i_stb[d] = 1'b1; i_pc[d] = pc;
        exp_iack[d][n+w] = 1'b1;
        exp_iadr[d][n+w] = pc;
        repeat (w + 1) begin
            @(negedge clk);
            i_pc[d] = pc ^ 13'h0AAA;
        end
        got = o_idat[d];
        i_cyc[d] = 1'b0; i_stb[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic abort_write(input int d, input bit [12:0] adr, input bit [15:0] dat);
        bit seen = 1'b0;
        d_cyc[d] = 1'b1; d_stb[d] = 1'b1; d_we[d] = 1'b1; d_adr[d] = adr; d_dati[d] = dat;
        @(negedge clk);
        @(negedge clk);
        d_cyc[d] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= o_dack[d];
        end
        d_stb[d] = 1'b0; d_we[d] = 1'b0;
        chk($sformatf("dut%0d abort_no_ack", d), {15'd0, seen}, 16'h0000);
    endtask

    task automatic rst_in_wait(input int d, input bit [12:0] adr, input bit [15:0] dat);
        d_cyc[d] = 1'b1; d_stb[d] = 1'b1; d_we[d] = 1'b1; d_adr[d] = adr; d_dati[d] = dat;
        @(negedge clk);
        rst[d] = 1'b1;
        d_cyc[d] = 1'b0; d_stb[d] = 1'b0; d_we[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("dut%0d rst_ack", d), {15'd0, o_dack[d]}, 16'h0000);
        chk($sformatf("dut%0d rst_dat", d), o_ddat[d], 16'h0000);
        rst[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit [15:0] g, g1, g2;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; d_cyc[d] = 1'b0; d_stb[d] = 1'b0; d_we[d] = 1'b0;
            d_adr[d] = '0; d_dati[d] = '0; i_cyc[d] = 1'b0; i_stb[d] = 1'b0; i_pc[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset_ack", d), {15'd0, o_dack[d]}, 16'h0000);
            chk($sformatf("dut%0d reset_inst_ack", d), {15'd0, o_iack[d]}, 16'h0000);
            chk($sformatf("dut%0d reset_dat", d), o_ddat[d], 16'h0000);
            chk($sformatf("dut%0d reset_inst", d), o_idat[d], 16'h0000);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        data_req(0, 1'b1, 13'h0020, 16'h0000, g);
        data_req(0, 1'b1, 13'h0FFF, 16'hA5A5, g);
        data_req(0, 1'b1, 13'h0000, 16'h5A5A, g);
        data_req(0, 1'b1, 13'h0010, 16'hBEEF, g);
        data_req(0, 1'b0, 13'h0010, 16'h0000, g);
        chk("readback_beef", g, 16'hBEEF);
        inst_req(0, 13'h0010, g);
        chk("inst_beef", g, 16'hBEEF);

        fork
            data_req(0, 1'b1, 13'h0020, 16'h1234, g1);
            begin @(negedge clk); inst_req(0, 13'h0020, g2); end
        join
        chk("same_cycle_old", g2, 16'h0000);
        inst_req(0, 13'h0020, g);
        chk("same_cycle_new", g, 16'h1234);

        fork
            data_req(0, 1'b1, 13'h0040, 16'h4040, g1);
            begin repeat (2) @(negedge clk); inst_req(0, 13'h0040, g2); end
        join
        chk("inst_after_commit", g2, 16'h4040);

        data_req(0, 1'b0, 13'h1FFF, 16'h0000, g);
        chk("oor_read", g, 16'h0000);
        data_req(0, 1'b1, 13'h1FFF, 16'hDEAD, g);
        data_req(0, 1'b0, 13'h0FFF, 16'h0000, g);
        chk("oor_keep_fff", g, 16'hA5A5);
        data_req(0, 1'b0, 13'h0000, 16'h0000, g);
        chk("oor_keep_000", g, 16'h5A5A);
        inst_req(0, 13'h1FFF, g);
        chk("oor_inst", g, 16'h0000);

        fork
            data_req(0, 1'b0, 13'h0010, 16'h0000, g1);
            inst_req(0, 13'h0000, g2);
        join
        chk("parallel_data", g1, 16'hBEEF);
        chk("parallel_inst", g2, 16'h5A5A);

        data_req(1, 1'b1, 13'h0030, 16'h3333, g);
        abort_write(1, 13'h0030, 16'h7777);
        data_req(1, 1'b0, 13'h0030, 16'h0000, g);
        chk("abort_keeps_mem", g, 16'h3333);
        rst_in_wait(1, 13'h0030, 16'h9999);
        data_req(1, 1'b0, 13'h0030, 16'h0000, g);
        chk("rst_keeps_mem", g, 16'h3333);
        data_req(1, 1'b1, 13'h0030, 16'h4444, g);
        inst_req(1, 13'h0030, g);
        chk("after_rst_inst", g, 16'h4444);
        data_req(1, 1'b0, 13'h0030, 16'h0000, g);
        chk("after_rst_data", g, 16'h4444);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
